op_result_serializer: RTL and testbench
=======================================

# op_result_serializer

Output-side serializer for the op_trans datapath. It captures one wide parallel result vector from a nonlinear or PE operator the same way those operators present it: a full `WIDTH*NUM` bus plus an active-low single-cycle valid. It then streams the vector out as fixed-width beats over a valid/ready handshake to the writeback/FIFO path. It also handles variable valid-element counts, masking, back-to-back vectors and overrun detection.

## Interface
Parameters:
- `WIDTH`, 8, bits per element
- `NUM`, 768, elements per input vector
- `BEAT`, 32, elements per output beat; `NUM` must be a multiple of `BEAT`
- `LEN_W`, 10, width of `in_len`; ≥ clog2(`NUM`+1)

Ports (one clock; reset is asynchronous and active-high):
- `clk_p` input 1: clock, rising edge
- `rst_p` input 1: asynchronous active-high reset
- `in_data` input `WIDTH*NUM`: element i at `[i*WIDTH +: WIDTH]`
- `in_valid_n` input 1: active-low; each low cycle is one vector request
- `in_len` input `LEN_W`: valid element count, sampled with `in_valid_n`
- `out_data` output `WIDTH*BEAT`: beat element j at `[j*WIDTH +: WIDTH]`
- `out_keep` output `BEAT`: bit j = element j of beat is valid
- `out_valid` output 1: beat available
- `out_ready` input 1: downstream accepts beat
- `out_last` output 1: current beat is final beat of vector
- `busy` output 1: high while in SEND
- `drop_err` output 1: sticky overrun flag

## Operation
- States: IDLE, SEND. Registers: vector buffer (`WIDTH*NUM`), `len_q`, `beat_cnt`, `nbeats`.
- Capture: sample `in_valid_n`==0 in IDLE. Latch `in_data` and set `len_q` = `in_len`.
  - If `in_len`==0 or `in_len`>`NUM`, set `len_q`=`NUM`.
  - Set `nbeats` = ceil(`len_q`/`BEAT`), `beat_cnt`=0, and go to SEND.
- SEND:
  - `out_valid`=1.
  - `out_data` element j = buffer element `beat_cnt*BEAT+j` if that index < `len_q`, else 0.
  - `out_keep[j]` is the same predicate.
  - `out_last` = (`beat_cnt`==`nbeats`-1).
- Handshake is `out_valid && out_ready`.
  - Non-last beat: `beat_cnt`++.
  - Last beat: return to IDLE.
- Back-to-back: if `in_valid_n`==0 in the same cycle as the last-beat handshake, capture the new vector and stay in SEND with `beat_cnt`=0. There is no bubble.
- Overrun: `in_valid_n`==0 in SEND, in any cycle other than the last-beat handshake:
  - The request is dropped and `drop_err` is set.
  - The current stream is unaffected.
  - `drop_err` clears only on reset.
- `out_valid`=0 means `out_data`=0, `out_keep`=0 and `out_last`=0.
- `busy` = (state==SEND).

## Timing
- Reset (async assert, synchronous-style release):
  - State IDLE, `beat_cnt`=0, `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `busy`=0, `drop_err`=0.
  - Vector buffer is not cleared.
- Latency: when `in_valid_n` is sampled low at edge t, `out_valid`=1 after edge t. First beat is presented in cycle t+1.
- With `out_ready` held high, a vector of `len_q` elements takes `nbeats` consecutive cycles. Full `NUM`=768 takes 24 cycles.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_keep` and `out_last` hold stable.
- `out_valid` never deasserts without a handshake, except on reset.
- `out_ready` may be high while `out_valid`=0; it has no effect.
- Reset mid-stream: outputs drop to reset values immediately on `rst_p` assertion. The partial vector is discarded. Operation resumes normally after release.
- `in_valid_n` held low for N cycles in IDLE: the first low cycle captures. The remaining cycles are overruns unless they land on the last-beat handshake.

## Test plan
1. Reset:
   - Stimulus: assert `rst_p` asynchronously mid-cycle.
   - Required: all outputs 0 before the next edge. After release and with no request, they stay 0 for 10 cycles.
2. Full vector:
   - Stimulus: element i = i mod 256, `in_len`=0, `out_ready`=1.
   - Required: 24 consecutive beats. Beat k element j = (32k+j)&0xFF. `out_keep`=all ones. `out_last` only on beat 23. `out_valid`=0 on cycle 25.
3. Partial length:
   - Stimulus: `in_len`=40.
   - Required: 2 beats. Beat 1 `out_keep`=0x000000FF, elements 8..31 = 0, `out_last`=1.
   - Also: `in_len`=1000 behaves as 768.
4. Backpressure:
   - Stimulus: `out_ready` = 1,0,0,1 repeating.
   - Required: each beat is held stable while stalled and is delivered exactly once, in order. Total 24 beats, no drop.
5. Overrun and back-to-back:
   - Stimulus: pulse `in_valid_n` during beat 5.
   - Required: `drop_err`=1 from the next cycle and the stream is unchanged.
   - Stimulus: pulse `in_valid_n` with vector B on the cycle of the final handshake of vector A.
   - Required: B beat 0 appears on the next cycle with `out_valid` continuously high and `drop_err` unaffected.
6. Reset mid-stream:
   - Stimulus: assert `rst_p` at beat 10 of 24.
   - Required: `out_valid`=0 and `busy`=0 immediately. After release, a new `in_len`=32 request yields exactly 1 beat with `out_last`=1.

Source files
------------

// File: rtl/op_result_serializer.sv
// ---------------------------------------------------------------------------
// op_result_serializer
//
// Captures one wide parallel result vector from an operator. The operator
// presents a full WIDTH*NUM bus together with a single-cycle, active-low
// valid. The vector is then streamed out as BEAT-element beats over a
// valid/ready handshake.
//
// Ports:
//   clk_p       rising-edge clock
//   rst_p       asynchronous active-high reset
//   in_data     input vector, element i at [i*WIDTH +: WIDTH]
//   in_valid_n  active-low request; every low cycle is one vector request
//   in_len      valid element count (0 or >NUM means NUM), sampled with request
//   out_data    beat data, element j at [j*WIDTH +: WIDTH], zero when not kept
//   out_keep    per-element valid mask of the current beat
//   out_valid   beat available
//   out_ready   downstream accepts the beat
//   out_last    current beat is the final beat of the vector
//   busy        high while a vector is being sent
//   drop_err    sticky: a request arrived while busy and was dropped
// ---------------------------------------------------------------------------
module op_result_serializer #(
    parameter int WIDTH = 8,
    parameter int NUM   = 768,
    parameter int BEAT  = 32,
    parameter int LEN_W = 10
) (
    input  logic                    clk_p,
    input  logic                    rst_p,
    input  logic [WIDTH*NUM-1:0]    in_data,
    input  logic                    in_valid_n,
    input  logic [LEN_W-1:0]        in_len,
    output logic [WIDTH*BEAT-1:0]   out_data,
    output logic [BEAT-1:0]         out_keep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    drop_err
);

    localparam int NBEATS = NUM / BEAT;
    // beat_cnt only ever holds 0..NBEATS-1, so it doubles as the beat index
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int IDX_W  = LEN_W + 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    // index of the final beat (nbeats-1), kept instead of nbeats
    logic [CNT_W-1:0]       last_q, last_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   drop_err_q, drop_err_d;
    logic [WIDTH*NUM-1:0]   vec_q, vec_d;

    logic                   req;
    logic                   send;
    logic                   hs;
    logic                   at_last;
    logic                   capture;
    logic [LEN_W-1:0]       len_eff;
    logic [CNT_W-1:0]       last_eff;
    logic [IDX_W-1:0]       beat_base;
    logic [WIDTH*BEAT-1:0]  beat_sel;
    logic [WIDTH*BEAT-1:0]  beat_arr [NBEATS];

    assign req     = !in_valid_n;
    assign send    = (state_q == S_SEND);
    assign hs      = send && out_ready;
    assign at_last = (beat_cnt_q == last_q);

    // A zero or oversize length means "whole vector"
    assign len_eff  = (in_len == '0 || in_len > LEN_W'(NUM)) ? LEN_W'(NUM) : in_len;
    assign last_eff = CNT_W'((IDX_W'(len_eff) + IDX_W'(BEAT - 1)) / IDX_W'(BEAT) - IDX_W'(1));

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        last_d     = last_q;
        len_d      = len_q;
        drop_err_d = drop_err_q;
        capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) capture = 1'b1;
            end
            S_SEND: begin
                if (hs && at_last) begin
                    // a request landing on the final handshake chains with no bubble
                    if (req) capture = 1'b1;
                    else     state_d = S_IDLE;
                end else begin
                    if (hs)  beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (req) drop_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            state_d    = S_SEND;
            beat_cnt_d = '0;
            len_d      = len_eff;
            last_d     = last_eff;
        end
    end

    assign vec_d = capture ? in_data : vec_q;

    // Vector buffer is intentionally left out of reset
    always_ff @(posedge clk_p) begin
        vec_q <= vec_d;
    end

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            last_q     <= '0;
            len_q      <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
            len_q      <= len_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Beat view of the buffer, selected by the beat counter
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
        assign beat_arr[gi] = vec_q[gi*BEAT*WIDTH +: BEAT*WIDTH];
    end
    assign beat_sel  = beat_arr[beat_cnt_q];
    assign beat_base = IDX_W'(beat_cnt_q) * IDX_W'(BEAT);

    // Elements past len_q are masked and zeroed; everything is zero outside SEND
    for (genvar gi = 0; gi < BEAT; gi++) begin : g_elem
        assign out_keep[gi] = send && ((beat_base + IDX_W'(gi)) < {1'b0, len_q});
        assign out_data[gi*WIDTH +: WIDTH] = out_keep[gi] ? beat_sel[gi*WIDTH +: WIDTH] : '0;
    end

    assign out_valid = send;
    assign busy      = send;
    assign out_last  = send && at_last;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_op_result_serializer.sv
module tb_op_result_serializer;

    localparam int WIDTH = 8;
    localparam int NUM   = 768;
    localparam int BEAT  = 32;
    localparam int LEN_W = 10;

    logic                   clk_p = 1'b0;
    logic                   rst_p;
    logic [WIDTH*NUM-1:0]   in_data;
    logic                   in_valid_n;
    logic [LEN_W-1:0]       in_len;
    logic [WIDTH*BEAT-1:0]  out_data;
    logic [BEAT-1:0]        out_keep;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   busy;
    logic                   drop_err;

    op_result_serializer #(
        .WIDTH(WIDTH), .NUM(NUM), .BEAT(BEAT), .LEN_W(LEN_W)
    ) dut (
        .clk_p      (clk_p),
        .rst_p      (rst_p),
        .in_data    (in_data),
        .in_valid_n (in_valid_n),
        .in_len     (in_len),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    initial forever #5 clk_p = ~clk_p;

    typedef struct {
        logic [WIDTH*BEAT-1:0] d;
        logic [BEAT-1:0]       k;
        logic                  l;
    } beat_t;

    typedef struct {
        int              len;
        int              mode;
        int              exp_beats;
        logic [BEAT-1:0] exp_last_keep;
    } vec_t;

    beat_t exp_q[$];
    vec_t  tbl[8];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int beats_seen;
    int cyc_n = 0;
    bit bp_en = 1'b0;
    bit stall_prev = 1'b0;
    bit seen_valid;
    logic [BEAT-1:0]       last_keep;
    logic [WIDTH*BEAT-1:0] held_d;
    logic [BEAT-1:0]       held_k;
    logic                  held_l;
    logic [WIDTH*NUM-1:0]  vec_a, vec_b;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [WIDTH*NUM-1:0] make_vec(input int mode);
        logic [WIDTH*NUM-1:0] v;
        for (int i = 0; i < NUM; i++)
            v[i*WIDTH +: WIDTH] = (mode == 0) ? WIDTH'(i) : WIDTH'($urandom);
        return v;
    endfunction

    // Expected beats straight from the element-level definition
    task automatic push_vec(input logic [WIDTH*NUM-1:0] v, input int len);
        int    l_eff;
        int    nb;
        beat_t b;
        l_eff = (len == 0 || len > NUM) ? NUM : len;
        nb    = (l_eff + BEAT - 1) / BEAT;
        for (int k = 0; k < nb; k++) begin
            b.d = '0;
            b.k = '0;
            for (int j = 0; j < BEAT; j++) begin
                if (k*BEAT + j < l_eff) begin
                    b.d[j*WIDTH +: WIDTH] = v[(k*BEAT + j)*WIDTH +: WIDTH];
                    b.k[j] = 1'b1;
                end
            end
            b.l = (k == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    // Sampled on the falling edge: the handshake seen here commits at the next rising edge
    task automatic monitor();
        beat_t b;
        seen_valid = out_valid;
        if (out_valid) begin
            chk("busy_high", busy, 1);
            if (stall_prev)
                chk("stall_hold", {out_data, out_keep, out_last}, {held_d, held_k, held_l});
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk($sformatf("beat%0d", beats_seen), {out_data, out_keep, out_last}, {b.d, b.k, b.l});
                end
                beats_seen++;
                last_keep = out_keep;
            end
            stall_prev = !out_ready;
            held_d = out_data;
            held_k = out_keep;
            held_l = out_last;
        end else begin
            if (stall_prev) chk("valid_dropped", 0, 1);
            stall_prev = 1'b0;
            chk("idle_zero", {out_data, out_keep, out_last, busy}, 0);
        end
    endtask

    task automatic cyc();
        @(negedge clk_p);
        monitor();
        @(posedge clk_p);
        #1;
        cyc_n++;
        if (bp_en) out_ready = (cyc_n % 4 == 0) || (cyc_n % 4 == 3);
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic send_vec(input logic [WIDTH*NUM-1:0] v, input int len);
        in_data    = v;
        in_len     = LEN_W'(len);
        in_valid_n = 1'b0;
        push_vec(v, len);
        cyc();
        in_valid_n = 1'b1;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst_p = 1'b1;
        #1;
        chk({tag, "_outs"}, {out_valid, busy, out_data, out_keep, out_last, drop_err}, 0);
        exp_q.delete();
        stall_prev = 1'b0;
        cyc();
        cyc();
        rst_p = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0] = '{0,    0, 24, 32'hFFFF_FFFF};
        tbl[1] = '{40,   1,  2, 32'h0000_00FF};
        tbl[2] = '{1000, 1, 24, 32'hFFFF_FFFF};
        tbl[3] = '{1,    1,  1, 32'h0000_0001};
        tbl[4] = '{32,   1,  1, 32'hFFFF_FFFF};
        tbl[5] = '{33,   1,  2, 32'h0000_0001};
        tbl[6] = '{767,  1, 24, 32'h7FFF_FFFF};
        tbl[7] = '{768,  1, 24, 32'hFFFF_FFFF};

        rst_p      = 1'b1;
        in_data    = '0;
        in_valid_n = 1'b1;
        in_len     = '0;
        out_ready  = 1'b1;
        beats_seen = 0;
        #1;
        chk("por_outs", {out_valid, busy, out_data, out_keep, out_last, drop_err}, 0);
        cyc();
        cyc();
        rst_p = 1'b0;

        // Asynchronous reset mid-cycle during a stream, then quiet idle
        vec_a = make_vec(0);
        send_vec(vec_a, 0);
        cyc();
        cyc();
        cyc();
        async_reset_check("rst_mid_cycle");
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("post_reset_idle", {out_valid, out_keep, out_last, busy, drop_err}, 0);
        end

        // Table of lengths, out_ready held high
        for (int t = 0; t < 8; t++) begin
            beats_seen = 0;
            vec_a = make_vec(tbl[t].mode);
            send_vec(vec_a, tbl[t].len);
            drain(100, n);
            chk($sformatf("len%0d_cycles", tbl[t].len), n, tbl[t].exp_beats);
            chk($sformatf("len%0d_beats", tbl[t].len), beats_seen, tbl[t].exp_beats);
            chk($sformatf("len%0d_last_keep", tbl[t].len), last_keep, tbl[t].exp_last_keep);
            chk($sformatf("len%0d_valid_after", tbl[t].len), out_valid, 0);
        end

        // Backpressure with ready pattern 1,0,0,1
        beats_seen = 0;
        bp_en = 1'b1;
        vec_a = make_vec(1);
        send_vec(vec_a, 0);
        drain(200, n);
        bp_en = 1'b0;
        out_ready = 1'b1;
        chk("bp_beats", beats_seen, 24);
        chk("bp_no_drop", drop_err, 0);
        cyc();

        // Back-to-back: B requested on A's final handshake
        beats_seen = 0;
        vec_a = make_vec(1);
        vec_b = make_vec(1);
        send_vec(vec_a, 64);
        cyc();
        chk("b2b_a0_valid", seen_valid, 1);
        send_vec(vec_b, 40);
        chk("b2b_a1_valid", seen_valid, 1);
        cyc();
        chk("b2b_b0_valid", seen_valid, 1);
        cyc();
        chk("b2b_b1_valid", seen_valid, 1);
        drain(10, n);
        chk("b2b_beats", beats_seen, 4);
        chk("b2b_no_drop", drop_err, 0);

        // Overrun during beat 5
        beats_seen = 0;
        vec_a = make_vec(1);
        send_vec(vec_a, 0);
        for (int i = 0; i < 5; i++) cyc();
        chk("ovr_before", drop_err, 0);
        in_data    = make_vec(1);
        in_len     = LEN_W'(5);
        in_valid_n = 1'b0;
        cyc();
        in_valid_n = 1'b1;
        chk("ovr_set", drop_err, 1);
        drain(100, n);
        chk("ovr_beats", beats_seen, 24);
        chk("ovr_sticky", drop_err, 1);
        cyc();

        // Reset at beat 10 of 24, then a single-beat vector
        beats_seen = 0;
        vec_a = make_vec(1);
        send_vec(vec_a, 0);
        for (int i = 0; i < 10; i++) cyc();
        async_reset_check("rst_mid_stream");
        cyc();
        beats_seen = 0;
        vec_b = make_vec(1);
        send_vec(vec_b, 32);
        drain(10, n);
        chk("post_rst_beats", beats_seen, 1);
        chk("post_rst_drop_clear", drop_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
